// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: word-side handshake and serial-side status of one UART TX channel.
//   i_Tx_DV / i_Tx_Byte : write strobe and payload word (master -> transmitter)
//   o_Tx_Ready          : holding register empty
//   o_Tx_Active         : frame (or break) on the line
//   o_Tx_Serial         : serial TX line, idles high
//   o_Tx_Done           : one-cycle pulse per completed frame
//   i_Break             : break request, present only with UART_TX_BREAK_EN defined
interface uart_tx_frame_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 i_Tx_DV;
    logic [DATA_BITS-1:0] i_Tx_Byte;
    logic                 o_Tx_Ready;
    logic                 o_Tx_Active;
    logic                 o_Tx_Serial;
    logic                 o_Tx_Done;
`ifdef UART_TX_BREAK_EN
    logic                 i_Break;

    modport master (
        output i_Tx_DV, i_Tx_Byte, i_Break,
        input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );
    modport slave (
        input  i_Tx_DV, i_Tx_Byte, i_Break,
        output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );
`else
    modport master (
        output i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );
    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
        output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );
`endif
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a one-entry holding register,
// allowing back-to-back frames with no idle gap between stop and next start bit.
//   i_Clock  : system clock, rising edge
//   i_Rst_n  : synchronous active-low reset
//   tx       : uart_tx_frame_if.slave (DV/Byte in; Ready/Active/Serial/Done out)
// Optional feature macro: UART_TX_BREAK_EN adds tx.i_Break and a BREAK state that
// holds the line low for at least one frame time, followed by one bit time of mark.
module uart_tx_frame #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic           i_Clock,
    input  logic           i_Rst_n,
    uart_tx_frame_if.slave tx
);
    localparam int unsigned CLK_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned STOP_W = 2;

    // Elaboration-time guard against parameter sets the datapath is not sized for.
    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
            $error("uart_tx_frame: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_BREAK_EN
        , S_BREAK
`endif
    } state_t;

    state_t               state, state_n;
    logic [CLK_W-1:0]     clk_cnt, clk_cnt_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [STOP_W-1:0]    stop_cnt, stop_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_bit, par_n;
    logic                 hold_valid, hold_valid_n;
    logic [DATA_BITS-1:0] hold_data, hold_data_n;
    logic                 serial, serial_n;
    logic                 active, active_n;
    logic                 done, done_n;
    logic                 load;
    logic                 bit_end;
    logic                 ready_c;

`ifdef UART_TX_BREAK_EN
    localparam int unsigned FRAME_CLKS =
        CLKS_PER_BIT * (1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS);
    localparam int unsigned BRK_W = $clog2(FRAME_CLKS);

    logic             brk_req, brk_req_n;
    logic [BRK_W-1:0] brk_cnt, brk_cnt_n;
    logic             brk_mark, brk_mark_n;

    // Break holds off new words until the line is back to idle.
    assign ready_c = ~hold_valid & (state != S_BREAK);
`else
    assign ready_c = ~hold_valid;
`endif

    assign bit_end = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));

    // State and datapath registers.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state      <= S_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            serial     <= 1'b1;
            active     <= 1'b0;
            done       <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_req    <= 1'b0;
            brk_cnt    <= '0;
            brk_mark   <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            clk_cnt    <= clk_cnt_n;
            bit_cnt    <= bit_cnt_n;
            stop_cnt   <= stop_cnt_n;
            shift      <= shift_n;
            par_bit    <= par_n;
            hold_valid <= hold_valid_n;
            hold_data  <= hold_data_n;
            serial     <= serial_n;
            active     <= active_n;
            done       <= done_n;
`ifdef UART_TX_BREAK_EN
            brk_req    <= brk_req_n;
            brk_cnt    <= brk_cnt_n;
            brk_mark   <= brk_mark_n;
`endif
        end
    end

    // Next-state, next-output and holding-register logic.
    always_comb begin
        state_n      = state;
        clk_cnt_n    = bit_end ? '0 : clk_cnt + CLK_W'(1);
        bit_cnt_n    = bit_cnt;
        stop_cnt_n   = stop_cnt;
        shift_n      = shift;
        par_n        = par_bit;
        hold_valid_n = hold_valid;
        hold_data_n  = hold_data;
        serial_n     = serial;
        active_n     = active;
        done_n       = 1'b0;
        load         = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_req_n    = brk_req | tx.i_Break;
        brk_cnt_n    = brk_cnt;
        brk_mark_n   = brk_mark;
`endif

        case (state)
            S_IDLE: begin
                clk_cnt_n = '0;
                serial_n  = 1'b1;
                active_n  = 1'b0;
                // Buffered data always goes before a pending break.
                if (hold_valid) begin
                    load     = 1'b1;
                    state_n  = S_START;
                    serial_n = 1'b0;
                    active_n = 1'b1;
                end
`ifdef UART_TX_BREAK_EN
                else if (brk_req | tx.i_Break) begin
                    state_n    = S_BREAK;
                    serial_n   = 1'b0;
                    active_n   = 1'b1;
                    brk_req_n  = 1'b0;
                    brk_cnt_n  = '0;
                    brk_mark_n = 1'b0;
                end
`endif
            end

            S_START: begin
                if (bit_end) begin
                    state_n   = S_DATA;
                    bit_cnt_n = '0;
                    serial_n  = shift[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            state_n  = S_PARITY;
                            serial_n = par_bit;
                        end else begin
                            state_n    = S_STOP;
                            serial_n   = 1'b1;
                            stop_cnt_n = STOP_W'(1);
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                        shift_n   = shift >> 1;
                        serial_n  = shift[1];
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_n    = S_STOP;
                    serial_n   = 1'b1;
                    stop_cnt_n = STOP_W'(1);
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (stop_cnt == STOP_W'(STOP_BITS)) begin
                        done_n = 1'b1;
                        // A buffered word starts on this same edge: no idle gap.
                        if (hold_valid) begin
                            load     = 1'b1;
                            state_n  = S_START;
                            serial_n = 1'b0;
                        end else begin
                            state_n  = S_IDLE;
                            serial_n = 1'b1;
                            active_n = 1'b0;
                        end
                    end else begin
                        stop_cnt_n = stop_cnt + STOP_W'(1);
                    end
                end
            end

`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                brk_req_n = 1'b0;
                active_n  = 1'b1;
                if (!brk_mark) begin
                    // Low phase: saturate at one frame time, then wait for release.
                    clk_cnt_n = '0;
                    serial_n  = 1'b0;
                    if (brk_cnt != BRK_W'(FRAME_CLKS - 1)) begin
                        brk_cnt_n = brk_cnt + BRK_W'(1);
                    end else if (!tx.i_Break) begin
                        brk_mark_n = 1'b1;
                        serial_n   = 1'b1;
                    end
                end else begin
                    // Mark-after-break lasts one bit time.
                    serial_n = 1'b1;
                    if (bit_end) begin
                        state_n    = S_IDLE;
                        active_n   = 1'b0;
                        brk_mark_n = 1'b0;
                    end
                end
            end
`endif

            default: begin
                state_n  = S_IDLE;
                serial_n = 1'b1;
                active_n = 1'b0;
            end
        endcase

        // Frame start: move the buffered word into the shifter and free the buffer.
        if (load) begin
            shift_n      = hold_data;
            par_n        = (^hold_data) ^ (PARITY == 1);
            hold_valid_n = 1'b0;
        end

        if (tx.i_Tx_DV && ready_c) begin
            hold_valid_n = 1'b1;
            hold_data_n  = tx.i_Tx_Byte;
        end
    end

    assign tx.o_Tx_Ready  = ready_c;
    assign tx.o_Tx_Active = active;
    assign tx.o_Tx_Serial = serial;
    assign tx.o_Tx_Done   = done;
endmodule
